// File: rtl/reversalmb_module.sv
// reversalmb_module: MBINIT REVERSALMB stage, sideband handshake with one lane-reversal retry.
// Optional response timeout is built when REVERSALMB_TIMEOUT_EN is defined.
module reversalmb_module #(
    parameter logic [19:0] TIMEOUT_CYCLES = 20'd800000
) (
    input  logic        CLK,
    input  logic        rst_n,
    input  logic        i_MBINIT_REVERSALMB_en,
    input  logic [3:0]  i_RX_SbMessage,
    input  logic        i_msg_valid,
    input  logic        i_Busy_SideBand,
    input  logic        i_falling_edge_busy,
    input  logic [15:0] i_RX_lane_result,
    input  logic        i_pattern_done,
    output logic [3:0]  o_TX_SbMessage,
    output logic        o_ValidOutData_REVERSALMB,
    output logic        o_pattern_en,
    output logic        o_lane_reversal,
    output logic        o_MBINIT_REVERSALMB_end,
    output logic        o_trainerror
);
    typedef enum logic [4:0] {
        IDLE, CHK_INIT, SEND_INIT, WAIT_INIT, CHK_CLR, SEND_CLR, WAIT_CLR,
        CHK_RES, SEND_RES, WAIT_RES, CHK_DONE, SEND_DONE, WAIT_DONE,
        PATTERN, EVAL, END, ERROR
    } state_t;

    state_t      state, nxt;
    logic        tried, tried_d, rev_d, sent, waiting, tmo_hit, valid_d;
    logic [3:0]  rsp, tx_d;
    logic [15:0] result_q;
    logic [4:0]  ones;

    assign rsp     = i_msg_valid ? i_RX_SbMessage : 4'b0000;
    assign sent    = i_falling_edge_busy & ~i_Busy_SideBand;
    assign ones    = 5'($countones(result_q));
    assign waiting = state inside {WAIT_INIT, WAIT_CLR, WAIT_RES, WAIT_DONE};

`ifdef REVERSALMB_TIMEOUT_EN
    logic [19:0] tmo_cnt;
    assign tmo_hit = waiting && tmo_cnt >= TIMEOUT_CYCLES - 20'd1;
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) tmo_cnt <= '0;
        else if (nxt != state) tmo_cnt <= '0;
        else if (waiting) tmo_cnt <= tmo_cnt + 20'd1;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        nxt     = state;
        rev_d   = o_lane_reversal;
        tried_d = tried;
        if (!i_MBINIT_REVERSALMB_en) begin
            nxt     = IDLE;
            rev_d   = 1'b0;
            tried_d = 1'b0;
        end else begin
            case (state)
                IDLE:      nxt = CHK_INIT;
                CHK_INIT:  nxt = i_Busy_SideBand ? CHK_INIT : SEND_INIT;
                SEND_INIT: nxt = sent ? WAIT_INIT : SEND_INIT;
                WAIT_INIT: nxt = rsp == 4'b0010 ? CHK_CLR : tmo_hit ? ERROR : WAIT_INIT;
                CHK_CLR:   nxt = i_Busy_SideBand ? CHK_CLR : SEND_CLR;
                SEND_CLR:  nxt = sent ? WAIT_CLR : SEND_CLR;
                WAIT_CLR:  nxt = rsp == 4'b0100 ? PATTERN : tmo_hit ? ERROR : WAIT_CLR;
                PATTERN:   nxt = i_pattern_done ? CHK_RES : PATTERN;
                CHK_RES:   nxt = i_Busy_SideBand ? CHK_RES : SEND_RES;
                SEND_RES:  nxt = sent ? WAIT_RES : SEND_RES;
                WAIT_RES:  nxt = rsp == 4'b0110 ? EVAL : tmo_hit ? ERROR : WAIT_RES;
                EVAL: begin
                    if (ones >= 5'd9) nxt = CHK_DONE;
                    else if (!tried) begin
                        nxt     = CHK_CLR;
                        rev_d   = 1'b1;
                        tried_d = 1'b1;
                    end else nxt = ERROR;
                end
                CHK_DONE:  nxt = i_Busy_SideBand ? CHK_DONE : SEND_DONE;
                SEND_DONE: nxt = sent ? WAIT_DONE : SEND_DONE;
                WAIT_DONE: nxt = rsp == 4'b1000 ? END : tmo_hit ? ERROR : WAIT_DONE;
                default:   nxt = state;
            endcase
        end
    end

    // Outputs are registered from the next state, so the strobe lands on the first SEND cycle
    assign tx_d = nxt == SEND_INIT ? 4'b0001 :
                  nxt == SEND_CLR  ? 4'b0011 :
                  nxt == SEND_RES  ? 4'b0101 :
                  nxt == SEND_DONE ? 4'b0111 : 4'b0000;
    assign valid_d = tx_d != 4'b0000 && nxt != state;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state                     <= IDLE;
            tried                     <= 1'b0;
            result_q                  <= '0;
            o_TX_SbMessage            <= 4'b0000;
            o_ValidOutData_REVERSALMB <= 1'b0;
            o_pattern_en              <= 1'b0;
            o_lane_reversal           <= 1'b0;
            o_MBINIT_REVERSALMB_end   <= 1'b0;
            o_trainerror              <= 1'b0;
        end else begin
            state                     <= nxt;
            tried                     <= tried_d;
            o_TX_SbMessage            <= tx_d;
            o_ValidOutData_REVERSALMB <= valid_d;
            o_pattern_en              <= nxt == PATTERN;
            o_lane_reversal           <= rev_d;
            o_MBINIT_REVERSALMB_end   <= nxt == END;
            o_trainerror              <= nxt == ERROR;
            if (state == WAIT_RES && nxt == EVAL) result_q <= i_RX_lane_result;
        end
    end
endmodule
